// File: rtl/relogio_param_alarme.sv
// Parametrised HH:MM:SS real-time clock with seconds prescaler, 12h/24h mode,
// validated load, one-hot/Johnson digit outputs, sub-minute segments and latched alarm.
module relogio_param_alarme #(
  parameter int CLK_DIV  = 1,
  parameter int MODE_12H = 0,
  parameter int SEG_N    = 4,
  parameter int ENC      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LD,
  input  logic [1:0]       H_in1,
  input  logic [3:0]       H_in0,
  input  logic [3:0]       M_in1,
  input  logic [3:0]       M_in0,
  input  logic [3:0]       S_in1,
  input  logic [3:0]       S_in0,
  input  logic             pm_in,
  input  logic             AL_LD,
  input  logic             alarm_en,
  input  logic             alarm_ack,
  output logic [9:0]       H_out1,
  output logic [9:0]       H_out0,
  output logic [9:0]       M_out1,
  output logic [9:0]       M_out0,
  output logic [9:0]       S_out1,
  output logic [9:0]       S_out0,
  output logic             pm,
  output logic [SEG_N-1:0] seg,
  output logic             sec_tick,
  output logic             alarm,
  output logic             load_err
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam int SEG_LEN = 60 / SEG_N;
  localparam logic [1:0] RST_H1 = (MODE_12H != 0) ? 2'd1 : 2'd0;
  localparam logic [3:0] RST_H0 = (MODE_12H != 0) ? 4'd2 : 4'd0;

  logic [PW-1:0] presc;
  logic [1:0]    h1, al_h1, n_h1;
  logic [3:0]    h0, m1, m0, s1, s0;
  logic [3:0]    al_h0, al_m1, al_m0;
  logic [3:0]    n_h0, n_m1, n_m0, n_s1, n_s0;
  logic          pm_r, n_pm;
  logic          tick, ld_valid, ld_ok, alarm_hit;
  logic [5:0]    hr_in, sec_v;

  assign tick     = (presc == PMAX);
  assign sec_tick = tick & ~LD;

  assign hr_in    = 6'(H_in1) * 6'd10 + 6'(H_in0);
  assign ld_valid = (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) &&
                    (S_in1 <= 4'd5) && (S_in0 <= 4'd9) &&
                    ((MODE_12H != 0) ? (hr_in >= 6'd1 && hr_in <= 6'd12)
                                     : (hr_in <= 6'd23));
  assign ld_ok    = LD & ld_valid;

  // Time value after one second; applied only on a tick.
  always_comb begin
    n_h1 = h1; n_h0 = h0; n_m1 = m1; n_m0 = m0; n_s1 = s1; n_s0 = s0; n_pm = pm_r;
    if (s0 != 4'd9) n_s0 = s0 + 4'd1;
    else begin
      n_s0 = 4'd0;
      if (s1 != 4'd5) n_s1 = s1 + 4'd1;
      else begin
        n_s1 = 4'd0;
        if (m0 != 4'd9) n_m0 = m0 + 4'd1;
        else begin
          n_m0 = 4'd0;
          if (m1 != 4'd5) n_m1 = m1 + 4'd1;
          else begin
            n_m1 = 4'd0;
            if (MODE_12H != 0) begin
              if (h1 == 2'd1 && h0 == 4'd2) begin
                n_h1 = 2'd0; n_h0 = 4'd1;
              end else if (h1 == 2'd1 && h0 == 4'd1) begin
                n_h0 = 4'd2; n_pm = ~pm_r;
              end else if (h0 == 4'd9) begin
                n_h1 = 2'd1; n_h0 = 4'd0;
              end else n_h0 = h0 + 4'd1;
            end else begin
              if (h1 == 2'd2 && h0 == 4'd3) begin
                n_h1 = 2'd0; n_h0 = 4'd0;
              end else if (h0 == 4'd9) begin
                n_h1 = h1 + 2'd1; n_h0 = 4'd0;
              end else n_h0 = h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  // Hour match ignores pm; compares the time the tick is about to produce.
  assign alarm_hit = alarm_en && tick && !ld_ok &&
                     (n_h1 == al_h1) && (n_h0 == al_h0) &&
                     (n_m1 == al_m1) && (n_m0 == al_m0) &&
                     (n_s1 == 4'd0) && (n_s0 == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      h1 <= RST_H1; h0 <= RST_H0; m1 <= 4'd0; m0 <= 4'd0; s1 <= 4'd0; s0 <= 4'd0;
      pm_r <= 1'b0;
      al_h1 <= 2'd0; al_h0 <= 4'd0; al_m1 <= 4'd0; al_m0 <= 4'd0;
      alarm <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= LD & ~ld_valid;
      if (ld_ok) begin
        presc <= '0;
        h1 <= H_in1; h0 <= H_in0; m1 <= M_in1; m0 <= M_in0; s1 <= S_in1; s0 <= S_in0;
        pm_r <= (MODE_12H != 0) ? pm_in : 1'b0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          h1 <= n_h1; h0 <= n_h0; m1 <= n_m1; m0 <= n_m0; s1 <= n_s1; s0 <= n_s0;
          pm_r <= n_pm;
        end
      end
      if (AL_LD) begin
        al_h1 <= H_in1; al_h0 <= H_in0; al_m1 <= M_in1; al_m0 <= M_in0;
      end
      if (alarm_hit) alarm <= 1'b1;
      else if (alarm_ack) alarm <= 1'b0;
    end
  end

  function automatic logic [9:0] enc_digit(input logic [3:0] d);
    logic [9:0] c;
    c = '0;
    if (ENC == 0) c = 10'b1 << d;
    else if (d < 4'd5) c[4:0] = (5'b00001 << d) - 5'd1;
    else c[4:0] = 5'b11111 << (d - 4'd5);
    return c;
  endfunction

  assign H_out1 = enc_digit({2'b00, h1});
  assign H_out0 = enc_digit(h0);
  assign M_out1 = enc_digit(m1);
  assign M_out0 = enc_digit(m0);
  assign S_out1 = enc_digit(s1);
  assign S_out0 = enc_digit(s0);
  assign pm     = pm_r;

  assign sec_v = 6'(s1) * 6'd10 + 6'(s0);

  always_comb begin
    seg = '0;
    for (int i = 0; i < SEG_N; i++) seg[i] = ((sec_v / 6'(SEG_LEN)) == 6'(i));
  end

endmodule
